// File: rtl/rf_rmw_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_rmw_initiator_if
//  Description : VALID/CONSUMED channel bundle between the read-modify-write
//                initiator (master) and its command source, result sink and
//                latency-insensitive register file (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_rmw_initiator_if #(
    parameter int width = 32,
    parameter int n     = 5
) ();

    // Command channel
    logic [1:0]       CMD_OP;
    logic [n-1:0]     CMD_INDEX;
    logic [width-1:0] CMD_DATA;
    logic             CMD_VALID;
    logic             CMD_CONSUMED;

    // Register file read request channel
    logic [n-1:0]     READ_REQ_WRITE;
    logic             READ_REQ_WRITE_VALID;
    logic             READ_REQ_WRITE_CONSUMED;

    // Register file read response channel
    logic [width-1:0] READ_RESP_READ;
    logic             READ_RESP_READ_VALID;
    logic             READ_RESP_READ_CONSUMED;

    // Register file write token (three fields, accepted together)
    logic             WRITE_EN_WRITE;
    logic             WRITE_EN_WRITE_VALID;
    logic             WRITE_EN_WRITE_CONSUMED;
    logic [n-1:0]     WRITE_INDEX_WRITE;
    logic             WRITE_INDEX_WRITE_VALID;
    logic             WRITE_INDEX_WRITE_CONSUMED;
    logic [width-1:0] WRITE_DATA_WRITE;
    logic             WRITE_DATA_WRITE_VALID;
    logic             WRITE_DATA_WRITE_CONSUMED;

    // Result channel
    logic [width-1:0] RES_DATA;
    logic             RES_VALID;
    logic             RES_CONSUMED;

    // Status
    logic             BUSY;

    modport master (
        input  CMD_OP, CMD_INDEX, CMD_DATA, CMD_VALID,
        output CMD_CONSUMED,
        output READ_REQ_WRITE, READ_REQ_WRITE_VALID,
        input  READ_REQ_WRITE_CONSUMED,
        input  READ_RESP_READ, READ_RESP_READ_VALID,
        output READ_RESP_READ_CONSUMED,
        output WRITE_EN_WRITE, WRITE_EN_WRITE_VALID,
        input  WRITE_EN_WRITE_CONSUMED,
        output WRITE_INDEX_WRITE, WRITE_INDEX_WRITE_VALID,
        input  WRITE_INDEX_WRITE_CONSUMED,
        output WRITE_DATA_WRITE, WRITE_DATA_WRITE_VALID,
        input  WRITE_DATA_WRITE_CONSUMED,
        output RES_DATA, RES_VALID,
        input  RES_CONSUMED,
        output BUSY
    );

    modport slave (
        output CMD_OP, CMD_INDEX, CMD_DATA, CMD_VALID,
        input  CMD_CONSUMED,
        input  READ_REQ_WRITE, READ_REQ_WRITE_VALID,
        output READ_REQ_WRITE_CONSUMED,
        output READ_RESP_READ, READ_RESP_READ_VALID,
        input  READ_RESP_READ_CONSUMED,
        input  WRITE_EN_WRITE, WRITE_EN_WRITE_VALID,
        output WRITE_EN_WRITE_CONSUMED,
        input  WRITE_INDEX_WRITE, WRITE_INDEX_WRITE_VALID,
        output WRITE_INDEX_WRITE_CONSUMED,
        input  WRITE_DATA_WRITE, WRITE_DATA_WRITE_VALID,
        output WRITE_DATA_WRITE_CONSUMED,
        input  RES_DATA, RES_VALID,
        output RES_CONSUMED,
        input  BUSY
    );

endinterface
`default_nettype wire

// File: rtl/rf_rmw_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : rf_rmw_initiator
//  Description : Atomic read-modify-write initiator for a latency-insensitive
//                register file. Accepts READ/WRITE/ADD/OR commands one at a
//                time, reads the target entry, issues exactly one write token
//                per consumed read response and returns the pre-update value.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_rmw_initiator #(
    parameter int width = 32,
    parameter int n     = 5
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    rf_rmw_initiator_if.master bus
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_OR    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Low during reset and for the cycle it is held, so no command is
    // accepted until the block has seen one clean edge out of reset.
    logic             armed;

    logic [1:0]       op;
    logic [n-1:0]     index;
    logic [width-1:0] operand;
    logic [width-1:0] old_val;
    logic [width-1:0] wr_data;
    logic             wr_en;

    logic             tok_done;
    logic             res_done;
    logic             tok_done_next;
    logic             res_done_next;

    logic             cmd_fire;
    logic             resp_fire;
    logic             tok_valid;
    logic             tok_fire;
    logic             res_valid;
    logic             res_fire;

    logic [width-1:0] new_data;
    logic             new_en;

    // The register file takes read requests without any completion tracking
    // on our side; the response channel alone advances the sequence.
    wire              unused_req_consumed = bus.READ_REQ_WRITE_CONSUMED;

    // ------------------------------------------------------------------
    // Channel decode: everything is a function of state and flags, except
    // the response consume which must follow the response valid directly.
    // ------------------------------------------------------------------
    assign tok_valid = (state == ST_FINISH) && !tok_done;
    assign res_valid = (state == ST_FINISH) && !res_done;

    assign bus.CMD_CONSUMED            = armed && (state == ST_IDLE);
    assign bus.READ_REQ_WRITE          = index;
    assign bus.READ_REQ_WRITE_VALID    = (state == ST_READ);
    assign bus.READ_RESP_READ_CONSUMED = (state == ST_READ) && bus.READ_RESP_READ_VALID;

    assign bus.WRITE_EN_WRITE             = wr_en;
    assign bus.WRITE_EN_WRITE_VALID       = tok_valid;
    assign bus.WRITE_INDEX_WRITE          = index;
    assign bus.WRITE_INDEX_WRITE_VALID    = tok_valid;
    assign bus.WRITE_DATA_WRITE           = wr_data;
    assign bus.WRITE_DATA_WRITE_VALID     = tok_valid;

    assign bus.RES_DATA  = old_val;
    assign bus.RES_VALID = res_valid;
    assign bus.BUSY      = (state != ST_IDLE);

    assign cmd_fire  = bus.CMD_VALID && bus.CMD_CONSUMED;
    assign resp_fire = bus.READ_RESP_READ_VALID && bus.READ_RESP_READ_CONSUMED;
    // The three token fields are always accepted together.
    assign tok_fire  = tok_valid
                    && bus.WRITE_EN_WRITE_CONSUMED
                    && bus.WRITE_INDEX_WRITE_CONSUMED
                    && bus.WRITE_DATA_WRITE_CONSUMED;
    assign res_fire  = res_valid && bus.RES_CONSUMED;

    // Modify step: new entry value and write enable from the old value.
    always_comb begin
        new_data = bus.READ_RESP_READ;
        new_en   = 1'b0;
        unique case (op)
            OP_READ: begin
                new_data = bus.READ_RESP_READ;
                new_en   = 1'b0;
            end
            OP_WRITE: begin
                new_data = operand;
                new_en   = 1'b1;
            end
            OP_ADD: begin
                new_data = bus.READ_RESP_READ + operand;
                new_en   = 1'b1;
            end
            OP_OR: begin
                new_data = bus.READ_RESP_READ | operand;
                new_en   = 1'b1;
            end
            default: begin
                new_data = bus.READ_RESP_READ;
                new_en   = 1'b0;
            end
        endcase
    end

    // Next-state and completion-flag logic for the command sequence.
    always_comb begin
        state_next    = state;
        tok_done_next = tok_done;
        res_done_next = res_done;
        unique case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (resp_fire) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                tok_done_next = tok_done || tok_fire;
                res_done_next = res_done || res_fire;
                if (tok_done_next && res_done_next) begin
                    state_next    = ST_IDLE;
                    tok_done_next = 1'b0;
                    res_done_next = 1'b0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                tok_done_next = 1'b0;
                res_done_next = 1'b0;
            end
        endcase
    end

    // State, completion flags and the post-reset arm bit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            tok_done <= 1'b0;
            res_done <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            tok_done <= tok_done_next;
            res_done <= res_done_next;
            armed    <= 1'b1;
        end
    end

    // Command latch on accept; old value and write token on read consume.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op      <= OP_READ;
            index   <= '0;
            operand <= '0;
            old_val <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op      <= bus.CMD_OP;
                index   <= bus.CMD_INDEX;
                operand <= bus.CMD_DATA;
            end
            if (resp_fire) begin
                old_val <= bus.READ_RESP_READ;
                wr_data <= new_data;
                wr_en   <= new_en;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rf_rmw_initiator.md
Name: rf_rmw_initiator

Overview:
- Command-side initiator that drives the read-request, read-response and write-token channels of a latency-insensitive register file (VALID/CONSUMED channels).
- Accepts one command at a time from upstream (READ, WRITE, ADD, OR), performs an atomic read-modify-write against the register file, and returns the pre-update value on a result channel.
- Guarantees exactly one write token (enable may be 0) per consumed read response, as the register file requires.

Parameters:
- width, 32, data width of register entries, command data and result.
- n, 5, index width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; synchronous, active-low.
- CMD_OP  in  2  command opcode: 0=READ, 1=WRITE, 2=ADD, 3=OR.
- CMD_INDEX  in  n  target register index.
- CMD_DATA  in  width  command operand.
- CMD_VALID  in  1  command present.
- CMD_CONSUMED  out  1  command accepted this cycle.
- READ_REQ_WRITE  out  n  read index to the register file.
- READ_REQ_WRITE_VALID  out  1  read request present.
- READ_REQ_WRITE_CONSUMED  in  1  read request taken.
- READ_RESP_READ  in  width  read data.
- READ_RESP_READ_VALID  in  1  read data present.
- READ_RESP_READ_CONSUMED  out  1  read data taken; also dequeues one write token inside the register file.
- WRITE_EN_WRITE  out  1  write enable field of the token.
- WRITE_EN_WRITE_VALID  out  1  enable field valid.
- WRITE_EN_WRITE_CONSUMED  in  1  enable field taken.
- WRITE_INDEX_WRITE  out  n  write index field.
- WRITE_INDEX_WRITE_VALID  out  1  index field valid.
- WRITE_INDEX_WRITE_CONSUMED  in  1  index field taken.
- WRITE_DATA_WRITE  out  width  write data field.
- WRITE_DATA_WRITE_VALID  out  1  data field valid.
- WRITE_DATA_WRITE_CONSUMED  in  1  data field taken.
- RES_DATA  out  width  pre-update register value.
- RES_VALID  out  1  result present.
- RES_CONSUMED  in  1  result taken.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Transfer on any channel occurs in a cycle where VALID && CONSUMED are both high at the rising CLK edge.
- States: IDLE, READ, FINISH.
- Reset (RST_N=0 at the edge): state goes to IDLE. All VALID outputs, CMD_CONSUMED, READ_RESP_READ_CONSUMED and BUSY are 0. Latched op, index, operand and result registers are cleared to 0.
- Reset mid-operation abandons the command with no further tokens issued. Restoring pairing in the register file is the environment's job: it resets the register file in the same cycle.
- IDLE:
  - CMD_CONSUMED = 1.
  - On a command transfer, latch op, index and data, then go to READ.
  - One-cycle accept latency.
- READ:
  - READ_REQ_WRITE = latched index; READ_REQ_WRITE_VALID = 1.
  - READ_RESP_READ_CONSUMED = READ_RESP_READ_VALID. CONSUMED is never asserted without VALID, because the register file dequeues on CONSUMED alone.
  - On consume: latch old = READ_RESP_READ, compute the new value, go to FINISH.
- New value by op:
  - READ: en=0, data=old.
  - WRITE: en=1, data=CMD_DATA.
  - ADD: en=1, data=(old+CMD_DATA) mod 2^width, carry discarded.
  - OR: en=1, data=old|CMD_DATA.
- Write token index = latched index for every op.
- FINISH: write token and result are issued in parallel, each tracked by its own done flag.
  - WRITE_*_VALID are all 1 until the token transfers. The token transfers when all three CONSUMED inputs are high with VALID in the same cycle. Partial field acceptance is not supported; the three CONSUMED inputs arrive together.
  - RES_VALID = 1 with RES_DATA = old until RES_CONSUMED.
  - Once both done flags are set (the same cycle if both complete together), clear the flags and return to IDLE.
  - Minimum command-to-command period is 3 cycles (IDLE→READ→FINISH→IDLE).
- The token written by command k takes effect in the array when command k+1's read is consumed. The register file forwards the pending write to a matching read index, so read-after-write is coherent.
- The first read after reset consumes the register file's preloaded no-op token.
- Outputs are registered or decoded from state only, except READ_RESP_READ_CONSUMED, which is combinational from READ_RESP_READ_VALID.

Test Plan:
- Reset, then WRITE idx3 data 0xAA (reg3=0x5) → RES_DATA=0x5; token en=1 idx3 data 0xAA. A following READ idx3 → RES_DATA=0xAA (forwarded), token en=0.
- ADD idx7 data 0x2, reg7=0xFFFFFFFF → RES_DATA=0xFFFFFFFF; token data=0x1; a later READ idx7 → 0x1.
- Back-pressure: hold RES_CONSUMED=0 for 4 cycles while the write token transfers immediately → WRITE_*_VALID drop after 1 cycle, RES_VALID held 4 cycles, BUSY stays high, CMD_CONSUMED=0 until the return to IDLE.
- READ_RESP_READ_VALID held low for 3 cycles in READ → READ_RESP_READ_CONSUMED stays 0 throughout; read completes on the first valid cycle.
- OR idx1 data 0xF0, reg1=0x0F → RES_DATA=0x0F, token data=0xFF. Back-to-back commands issue at 3-cycle spacing with no back-pressure.
- Assert RST_N=0 in FINISH with result pending → next cycle all VALIDs=0, BUSY=0, CMD_CONSUMED=0; after release, CMD_CONSUMED=1.
